// File: rtl/tinyalu_pkg.sv
// Shared definitions for the tinyALU responder: operation encodings and default parameters.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      NO_OP  = 3'b000,
      ADD_OP = 3'b001,
      AND_OP = 3'b010,
      XOR_OP = 3'b011,
      MUL_OP = 3'b100,
      OR_OP  = 3'b101,
      MAD_OP = 3'b110,
      ILL_OP = 3'b111
   } operation_t;

   localparam logic [2:0] OPC_NO  = 3'b000;
   localparam logic [2:0] OPC_ADD = 3'b001;
   localparam logic [2:0] OPC_AND = 3'b010;
   localparam logic [2:0] OPC_XOR = 3'b011;
   localparam logic [2:0] OPC_MUL = 3'b100;
   localparam logic [2:0] OPC_OR  = 3'b101;
   localparam logic [2:0] OPC_MAD = 3'b110;
   localparam logic [2:0] OPC_ILL = 3'b111;

   localparam int DATA_W_DEF  = 8;
   localparam int MUL_LAT_DEF = 3;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered A*B pipeline with a valid shift chain. The core's result register
// acts as the final stage, so STAGES is MUL_LAT-1 here.
module tinyalu_mul_pipe #(
   parameter int DATA_W = 8,
   parameter int STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  out_valid,
   output logic [2*DATA_W-1:0]   prod
);

   localparam int RES_W = 2 * DATA_W;

   logic [RES_W-1:0]  prod_d [STAGES];
   logic [RES_W-1:0]  prod_q [STAGES];
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] valid_q;

   always_comb begin
      prod_d[0]  = RES_W'(a) * RES_W'(b);
      valid_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
         prod_d[i]  = prod_q[i-1];
         valid_d[i] = valid_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            prod_q[i] <= {RES_W{1'b0}};
         end
         valid_q <= {STAGES{1'b0}};
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            prod_q[i] <= prod_d[i];
         end
         valid_q <= valid_d;
      end
   end

   assign prod      = prod_q[STAGES-1];
   assign out_valid = valid_q[STAGES-1];

endmodule

// File: rtl/tinyalu_core.sv
// tinyALU responder: start/done handshake FSM, single-cycle logic/add ops and
// pipelined mul/mad with a held 2*DATA_W result.
module tinyalu_core
   import tinyalu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic [DATA_W-1:0]     C,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result,
   output logic                  err
);

   localparam int RES_W = 2 * DATA_W;
   localparam int CNT_W = $clog2(MUL_LAT + 2);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY    = 2'b01,
      DONE    = 2'b10,
      RELEASE = 2'b11
   } state_t;

   state_t           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             done_d, done_q;
   logic             err_d, err_q;
   logic [RES_W-1:0] result_d, result_q;
   logic [RES_W-1:0] mad_d, mad_q;
   logic [DATA_W-1:0] c_d, c_q;
   operation_t       op_d, op_q;
   operation_t       op_s;
   logic [RES_W-1:0] alu_s;
   logic             mul_start_s;
   logic             mul_valid_s;
   logic [RES_W-1:0] mul_prod_s;

   assign op_s = operation_t'(op);

   always_comb begin
      case (op_s)
         ADD_OP:  alu_s = RES_W'(A) + RES_W'(B);
         AND_OP:  alu_s = RES_W'(A & B);
         XOR_OP:  alu_s = RES_W'(A ^ B);
         OR_OP:   alu_s = RES_W'(A | B);
         default: alu_s = {RES_W{1'b0}};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      result_d    = result_q;
      c_d         = c_q;
      op_d        = op_q;
      mul_start_s = 1'b0;
      // mad adds C in the stage after the multiplier output appears
      if (mul_valid_s && (op_q == MAD_OP)) begin
         mad_d = mul_prod_s + RES_W'(c_q);
      end else begin
         mad_d = mad_q;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op_s)
                  ADD_OP, AND_OP, XOR_OP, OR_OP: begin
                     op_d     = op_s;
                     c_d      = C;
                     result_d = alu_s;
                     done_d   = 1'b1;
                     state_d  = DONE;
                  end
                  MUL_OP: begin
                     op_d        = op_s;
                     c_d         = C;
                     cnt_d       = CNT_W'(MUL_LAT - 1);
                     mul_start_s = 1'b1;
                     state_d     = BUSY;
                  end
                  MAD_OP: begin
                     op_d        = op_s;
                     c_d         = C;
                     cnt_d       = CNT_W'(MUL_LAT);
                     mul_start_s = 1'b1;
                     state_d     = BUSY;
                  end
                  ILL_OP: begin
                     err_d   = 1'b1;
                     state_d = RELEASE;
                  end
                  default: begin
                     state_d = IDLE;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d = (op_q == MAD_OP) ? mad_q : mul_prod_s;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            state_d = start ? RELEASE : IDLE;
         end
         RELEASE: begin
            state_d = start ? RELEASE : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= {RES_W{1'b0}};
         mad_q    <= {RES_W{1'b0}};
         c_q      <= {DATA_W{1'b0}};
         op_q     <= NO_OP;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
         mad_q    <= mad_d;
         c_q      <= c_d;
         op_q     <= op_d;
      end
   end

   tinyalu_mul_pipe #(
      .DATA_W (DATA_W),
      .STAGES (MUL_LAT - 1)
   ) u_mul_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mul_start_s),
      .a         (A),
      .b         (B),
      .out_valid (mul_valid_s),
      .prod      (mul_prod_s)
   );

   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed self-checking bench for tinyalu_core: inputs driven and outputs sampled on negedge.
module tb_tinyalu_core;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [7:0]  C;
   logic        done;
   logic [15:0] result;
   logic        err;

   int n_cmp;
   int n_bad;

   tinyalu_core #(.DATA_W(8), .MUL_LAT(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .C      (C),
      .done   (done),
      .result (result),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one command from a negedge, holds start until done (bounded), then drops start.
   // lat counts posedges from the drive point to the first sample with done=1, -1 on timeout.
   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, output int lat, output logic [15:0] res);
      op = o; A = a; B = b; C = c; start = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      res = result;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 3'b000; A = 8'h00; B = 8'h00; C = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got=%h exp=0000", result); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      int lat; logic [15:0] res;
      issue(3'b001, 8'hFF, 8'h01, 8'h00, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h0100) begin n_bad++; $display("FAIL add_result got=%h exp=0100", res); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_width got=%b exp=0", done); end
      n_cmp++; if (result !== 16'h0100) begin n_bad++; $display("FAIL add_result_held got=%h exp=0100", result); end
   endtask

   task automatic test_logic();
      int lat; logic [15:0] res;
      issue(3'b011, 8'hA5, 8'h0F, 8'h00, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL xor_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h00AA) begin n_bad++; $display("FAIL xor_result got=%h exp=00AA", res); end
      @(posedge clk); @(negedge clk);
      issue(3'b101, 8'hF0, 8'h0F, 8'h00, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL or_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h00FF) begin n_bad++; $display("FAIL or_result got=%h exp=00FF", res); end
      @(posedge clk); @(negedge clk);
      issue(3'b010, 8'hF0, 8'h3C, 8'h00, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL and_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h0030) begin n_bad++; $display("FAIL and_result got=%h exp=0030", res); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_mul();
      int lat; logic [15:0] res;
      issue(3'b100, 8'd255, 8'd255, 8'd0, lat, res);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mul_latency got=%0d exp=3", lat); end
      n_cmp++; if (res !== 16'hFE01) begin n_bad++; $display("FAIL mul_result got=%h exp=FE01", res); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mul_done_width got=%b exp=0", done); end
   endtask

   task automatic test_mad();
      int lat; logic [15:0] res;
      issue(3'b110, 8'd10, 8'd20, 8'd5, lat, res);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL mad_latency got=%0d exp=4", lat); end
      n_cmp++; if (res !== 16'h00CD) begin n_bad++; $display("FAIL mad_result got=%h exp=00CD", res); end
      @(posedge clk); @(negedge clk);
      issue(3'b110, 8'd255, 8'd255, 8'd255, lat, res);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL mad_max_latency got=%0d exp=4", lat); end
      n_cmp++; if (res !== 16'hFF00) begin n_bad++; $display("FAIL mad_max_result got=%h exp=FF00", res); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_no_op();
      int dones;
      dones = 0;
      op = 3'b000; A = 8'h12; B = 8'h34; C = 8'h56; start = 1'b1;
      @(posedge clk); @(negedge clk);
      if (done) dones++;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL noop_done got=%0d exp=0", dones); end
      n_cmp++; if (result !== 16'hFF00) begin n_bad++; $display("FAIL noop_result got=%h exp=FF00", result); end
   endtask

   task automatic test_illegal();
      int dones;
      dones = 0;
      op = 3'b111; A = 8'h01; B = 8'h02; C = 8'h03; start = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b exp=1", err); end
      if (done) dones++;
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal_err_width got=%b exp=0", err); end
      if (done) dones++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL illegal_done got=%0d exp=0", dones); end
      n_cmp++; if (result !== 16'hFF00) begin n_bad++; $display("FAIL illegal_result got=%h exp=FF00", result); end
   endtask

   task automatic test_held_start();
      int dones; int lat; logic [15:0] res;
      dones = 0;
      op = 3'b001; A = 8'd1; B = 8'd2; C = 8'd0; start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) dones++;
      end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL held_single_done got=%0d exp=1", dones); end
      n_cmp++; if (result !== 16'h0003) begin n_bad++; $display("FAIL held_result got=%h exp=0003", result); end
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      issue(3'b001, 8'd5, 8'd6, 8'd0, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL held_next_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h000B) begin n_bad++; $display("FAIL held_next_result got=%h exp=000B", res); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset_mid_mul();
      int dones; int lat; logic [15:0] res;
      dones = 0;
      op = 3'b100; A = 8'd5; B = 8'd6; C = 8'd0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      if (done) dones++;
      reset = 1'b1; start = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         if (done) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_done got=%0d exp=0", dones); end
      n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL abort_result got=%h exp=0000", result); end
      issue(3'b001, 8'd3, 8'd4, 8'd0, lat, res);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL post_reset_latency got=%0d exp=1", lat); end
      n_cmp++; if (res !== 16'h0007) begin n_bad++; $display("FAIL post_reset_result got=%h exp=0007", res); end
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1; start = 1'b0; op = 3'b000; A = 8'h00; B = 8'h00; C = 8'h00;
      @(negedge clk);
      test_reset();
      test_add();
      test_logic();
      test_mul();
      test_mad();
      test_no_op();
      test_illegal();
      test_held_start();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
